// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply engine.
//   state_t    : engine sequencing states
//   acc_width  : accumulator width that holds K_MAX full-width products exactly
//   slice_lo   : low bit index of element idx in a flat bus of w-bit elements
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int acc_width(input int w, input int k_max);
        return 2 * w + $clog2(k_max);
    endfunction

    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/systolic_pe_mac.sv
// One processing element of the output-stationary array.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clr            load acc with this cycle's product instead of adding
//   mode           1 = operands are signed two's complement, 0 = unsigned
//   a_in, b_in     operands arriving from the left / from above
//   a_out, b_out   registered operands passed to the right / downward
//   acc            running dot product, wraps modulo 2^ACC_W
module systolic_pe_mac #(
    parameter int W     = 16,
    parameter int ACC_W = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             mode,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;

    // Extending both operands to ACC_W and multiplying modulo 2^ACC_W gives the
    // exact product, already extended, for either signedness.
    always_comb begin
        if (mode) begin
            a_ext = ACC_W'($signed(a_in));
            b_ext = ACC_W'($signed(b_in));
        end else begin
            a_ext = ACC_W'(a_in);
            b_ext = ACC_W'(b_in);
        end
        prod = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= clr ? prod : acc + prod;
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic engine computing C = A(N x K) * B(K x N).
// One beat carries column k of A and row k of B; rows of C leave one per
// handshake once the array has flushed.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_mode              0 unsigned / 1 signed, taken from a job's first beat
//   i_valid, o_ready    input beat handshake; i_last tags beat K-1
//   i_A, i_B            A column (element i at [i*W +: W]), B row (j at [j*W +: W])
//   o_valid, i_ready    result row handshake
//   o_C, o_row, o_last  row o_row of C (element j at [j*ACC_W +: ACC_W]), last row flag
//   o_overflow          sticky: current job has more than K_MAX beats
//
// state | meaning
// IDLE  | waiting for the first beat of a job
// LOAD  | accepting further beats until i_last
// FLUSH | 2N-2 cycles of zeros pushing the last beat through the skew
// DRAIN | presenting rows 0..N-1 of C
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int N     = 4,
    parameter  int K_MAX = 16,
    localparam int ACC_W = acc_width(W, K_MAX),
    localparam int RW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_mode,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_last,
    input  logic [W*N-1:0]     i_A,
    input  logic [W*N-1:0]     i_B,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ACC_W*N-1:0] o_C,
    output logic [RW-1:0]      o_row,
    output logic               o_last,
    output logic               o_overflow
);

    localparam int CW = $clog2(K_MAX + 2);
    localparam int FW = $clog2(2 * N);

    state_t          state_q, state_d;
    logic            accept, first_beat, row_hs, last_row, flush_done;
    logic            mode_q, mode_cur;
    logic [CW-1:0]   beat_cnt_q;
    logic [FW-1:0]   flush_cnt_q;
    logic [RW-1:0]   row_q;

    logic [N-1:0][W-1:0]            a_inj, b_inj, a_lane, b_lane;
    logic [N-1:0][N-1:0][W-1:0]     a_pass, b_pass;
    logic [N-1:0][N-1:0][ACC_W-1:0] acc;
    logic [N-1:0][W-1:0]            a_edge_unused, b_edge_unused;

    assign accept     = i_valid & o_ready;
    assign first_beat = accept & (state_q == IDLE);
    assign row_hs     = o_valid & i_ready;
    assign last_row   = (int'(row_q) == N - 1);
    assign flush_done = (int'(flush_cnt_q) == 2 * N - 3);
    // PE(0,0) consumes the first beat in the same cycle the mode is latched.
    assign mode_cur   = (state_q == IDLE) ? i_mode : mode_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (i_last) state_d = (N == 1) ? DRAIN : FLUSH;
                    else        state_d = LOAD;
                end
            end
            FLUSH:   if (flush_done) state_d = DRAIN;
            DRAIN:   if (row_hs && last_row) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == IDLE) || (state_q == LOAD);
        o_valid = (state_q == DRAIN);
        o_last  = (state_q == DRAIN) && last_row;
        o_row   = row_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q      <= 1'b0;
            o_overflow  <= 1'b0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_q       <= '0;
        end else begin
            if (first_beat) begin
                mode_q     <= i_mode;
                o_overflow <= 1'b0;
                beat_cnt_q <= CW'(1);
            end else if (accept) begin
                if (beat_cnt_q == CW'(K_MAX))     o_overflow <= 1'b1;
                if (beat_cnt_q != CW'(K_MAX + 1)) beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;
            if (row_hs) row_q <= last_row ? '0 : row_q + 1'b1;
        end
    end

    // Unaccepted cycles inject zeros so bubbles and flushing add nothing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = accept ? i_A[slice_lo(i, W) +: W] : '0;
            b_inj[i] = accept ? i_B[slice_lo(i, W) +: W] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_lane[0] = a_inj[0];
            assign b_lane[0] = b_inj[0];
        end else begin : g_delay
            logic [i-1:0][W-1:0] a_sr, b_sr;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_sr <= '0;
                    b_sr <= '0;
                end else begin
                    a_sr[0] <= a_inj[i];
                    b_sr[0] <= b_inj[i];
                    for (int s = 1; s < i; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end
            assign a_lane[i] = a_sr[i-1];
            assign b_lane[i] = b_sr[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [W-1:0] a_src, b_src;
            if (j == 0) begin : g_a_edge
                assign a_src = a_lane[i];
            end else begin : g_a_chain
                assign a_src = a_pass[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_src = b_lane[j];
            end else begin : g_b_chain
                assign b_src = b_pass[i-1][j];
            end
            systolic_pe_mac #(.W(W), .ACC_W(ACC_W)) u_pe (
                .clk   (i_clk),
                .rst_n (i_rst_n),
                .clr   (first_beat),
                .mode  (mode_cur),
                .a_in  (a_src),
                .b_in  (b_src),
                .a_out (a_pass[i][j]),
                .b_out (b_pass[i][j]),
                .acc   (acc[i][j])
            );
        end
        // Operands leaving the far edge of the array are dropped.
        assign a_edge_unused[i] = a_pass[i][N-1];
        assign b_edge_unused[i] = b_pass[N-1][i];
    end

    always_comb begin
        o_C = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < N; j++) o_C[j*ACC_W +: ACC_W] = acc[row_q][j];
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
module tb_systolic_mm_engine;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int ACC_W = 36;
    localparam int RW    = 2;

    logic               clk;
    logic               rst_n;
    logic               i_mode, i_valid, i_last, i_ready;
    logic [W*N-1:0]     i_A, i_B;
    logic               o_ready, o_valid, o_last, o_overflow;
    logic [ACC_W*N-1:0] o_C;
    logic [RW-1:0]      o_row;

    systolic_mm_engine #(.W(W), .N(N), .K_MAX(K_MAX)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_mode     (i_mode),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_last     (i_last),
        .i_A        (i_A),
        .i_B        (i_B),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_C        (o_C),
        .o_row      (o_row),
        .o_last     (o_last),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]       a_m [0:31][0:N-1];
    logic [W-1:0]       b_m [0:31][0:N-1];
    logic [ACC_W*N-1:0] sb_q [$];
    int                 acc_first_cyc, acc_last_cyc, hs_last_cyc;

    function automatic longint ext(input logic [W-1:0] v, input bit m);
        return m ? longint'($signed(v)) : longint'(v);
    endfunction

    task automatic push_model(input int k_len, input bit mode);
        logic [ACC_W*N-1:0] row;
        longint s;
        for (int r = 0; r < N; r++) begin
            row = '0;
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < k_len; k++) s += ext(a_m[k][r], mode) * ext(b_m[k][c], mode);
                row[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
            end
            sb_q.push_back(row);
        end
    endtask

    task automatic push_const(input logic [ACC_W-1:0] v);
        logic [ACC_W*N-1:0] row;
        for (int c = 0; c < N; c++) row[c*ACC_W +: ACC_W] = v;
        for (int r = 0; r < N; r++) sb_q.push_back(row);
    endtask

    task automatic fill_random(input int k_len);
        for (int k = 0; k < k_len; k++)
            for (int i = 0; i < N; i++) begin
                a_m[k][i] = W'($urandom);
                b_m[k][i] = W'($urandom);
            end
    endtask

    // Drives k_len beats from a_m/b_m; beat presented in cycle T is accepted at
    // the edge closing T. Overflow is checked right after every accepted beat.
    task automatic send_job(input int k_len, input bit mode, input int gap_max, input bit use_model);
        int gap, waited;
        if (use_model) push_model(k_len, mode);
        for (int k = 0; k < k_len; k++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gap; g++) @(negedge clk);
            @(negedge clk);
            i_valid = 1'b1;
            i_last  = (k == k_len - 1);
            i_mode  = mode;
            for (int i = 0; i < N; i++) begin
                i_A[i*W +: W] = a_m[k][i];
                i_B[i*W +: W] = b_m[k][i];
            end
            waited = 0;
            while (!o_ready && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (!o_ready) begin
                checks++; errors++;
                $display("FAIL send_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, waited);
                i_valid = 1'b0;
                return;
            end
            if (k == 0) acc_first_cyc = cyc;
            acc_last_cyc = cyc;
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
            checks++;
            if (o_overflow !== (k + 1 > K_MAX)) begin
                errors++;
                $display("FAIL overflow_beat%0d: got=%0b exp=%0b", k + 1, o_overflow, (k + 1 > K_MAX));
            end
        end
    endtask

    task automatic recv_job(input int stall_row, input int stall_len, input int t_last, input bit chk_lat);
        int r, stalled, budget;
        bit seen;
        logic [ACC_W*N-1:0] exp_row, held_c;
        logic [RW-1:0] held_row, exp_r;
        r = 0; stalled = 0; budget = 0; seen = 0;
        held_c = '0; held_row = '0;
        while (r < N && budget < 200) begin
            @(negedge clk);
            budget++;
            if (seen) begin
                checks++;
                if (o_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL row_gap: o_valid=%0b before row %0d, required 1", o_valid, r);
                end
            end
            if (o_valid !== 1'b1) begin
                i_ready = 1'b1;
                continue;
            end
            if (!seen) begin
                seen = 1;
                if (chk_lat) begin
                    checks++;
                    if (cyc != t_last + 2 * N - 1) begin
                        errors++;
                        $display("FAIL latency: first valid cycle=%0d exp=%0d", cyc, t_last + 2 * N - 1);
                    end
                end
            end
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_row: row=%0d with empty scoreboard", o_row);
                i_ready = 1'b1; r++;
                continue;
            end
            exp_row = sb_q[0];
            exp_r   = r[RW-1:0];
            checks++;
            if (o_C !== exp_row) begin
                errors++;
                $display("FAIL row%0d_data: got=%h exp=%h", r, o_C, exp_row);
            end
            checks++;
            if (o_row !== exp_r) begin
                errors++;
                $display("FAIL row_index: got=%0d exp=%0d", o_row, exp_r);
            end
            checks++;
            if (o_last !== (r == N - 1)) begin
                errors++;
                $display("FAIL row%0d_last: got=%0b exp=%0b", r, o_last, (r == N - 1));
            end
            if (r == stall_row && stalled > 0) begin
                checks++;
                if (o_C !== held_c || o_row !== held_row) begin
                    errors++;
                    $display("FAIL stall_hold: got row=%0d C=%h exp row=%0d C=%h", o_row, o_C, held_row, held_c);
                end
            end
            if (r == stall_row && stalled < stall_len) begin
                held_c = o_C; held_row = o_row;
                stalled++;
                i_ready = 1'b0;
            end else begin
                i_ready = 1'b1;
                void'(sb_q.pop_front());
                if (r == N - 1) hs_last_cyc = cyc;
                r++;
            end
        end
        if (r < N) begin
            checks++; errors++;
            $display("FAIL recv_timeout: got %0d rows exp %0d", r, N);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_C !== '0 || o_row !== '0 ||
            o_last !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s: ready=%0b valid=%0b C=%h row=%0d last=%0b ovf=%0b exp 1 0 0 0 0 0",
                     tag, o_ready, o_valid, o_C, o_row, o_last, o_overflow);
        end
    endtask

    task automatic load_identity();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                a_m[k][i] = W'(i == k);
                b_m[k][i] = W'(k * N + i + 1);
            end
    endtask

    task automatic push_identity();
        logic [ACC_W*N-1:0] row;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) row[c*ACC_W +: ACC_W] = ACC_W'(r * N + c + 1);
            sb_q.push_back(row);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_identity();
        load_identity();
        push_identity();
        send_job(N, 1'b0, 0, 1'b0);
        recv_job(-1, 0, acc_last_cyc, 1'b1);
    endtask

    task automatic test_sign();
        for (int i = 0; i < N; i++) begin
            a_m[0][i] = 16'hFFFE;
            b_m[0][i] = 16'h0003;
        end
        push_const(36'hFFFFFFFFA);
        send_job(1, 1'b1, 0, 1'b0);
        recv_job(-1, 0, acc_last_cyc, 1'b1);
        push_const(36'h00002FFFA);
        send_job(1, 1'b0, 0, 1'b0);
        recv_job(-1, 0, acc_last_cyc, 1'b1);
    endtask

    task automatic test_bubbles();
        fill_random(3);
        send_job(3, 1'b1, 3, 1'b1);
        recv_job(1, 5, acc_last_cyc, 1'b1);
        fill_random(3);
        send_job(3, 1'b0, 3, 1'b1);
        recv_job(2, 3, acc_last_cyc, 1'b1);
    endtask

    task automatic test_overflow();
        for (int k = 0; k < K_MAX + 1; k++)
            for (int i = 0; i < N; i++) begin
                a_m[k][i] = 16'hFFFF;
                b_m[k][i] = 16'hFFFF;
            end
        push_const(36'h0FFDE0011);
        send_job(K_MAX + 1, 1'b0, 0, 1'b0);
        recv_job(-1, 0, acc_last_cyc, 1'b1);
        @(negedge clk);
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got=%0b exp=1", o_overflow);
        end
        fill_random(2);
        send_job(2, 1'b0, 0, 1'b1);
        recv_job(-1, 0, acc_last_cyc, 1'b1);
    endtask

    task automatic test_reset_flush();
        int vcount;
        fill_random(2);
        send_job(2, 1'b1, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_flush");
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_valid) vcount++;
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL no_partial_result: valid cycles=%0d exp=0", vcount);
        end
        load_identity();
        push_identity();
        send_job(N, 1'b0, 0, 1'b0);
        recv_job(-1, 0, acc_last_cyc, 1'b1);
    endtask

    task automatic test_back_to_back();
        int t1;
        fill_random(2);
        send_job(2, 1'b1, 0, 1'b1);
        t1 = acc_last_cyc;
        fill_random(3);
        fork
            send_job(3, 1'b0, 0, 1'b1);
            recv_job(-1, 0, t1, 1'b1);
        join
        checks++;
        if (acc_first_cyc != hs_last_cyc + 1) begin
            errors++;
            $display("FAIL b2b_accept_cycle: got=%0d exp=%0d", acc_first_cyc, hs_last_cyc + 1);
        end
        recv_job(-1, 0, acc_last_cyc, 1'b1);
    endtask

    initial begin
        rst_n   = 1'b1;
        i_mode  = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        i_A     = '0;
        i_B     = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_identity();
        test_sign();
        test_bubbles();
        test_overflow();
        test_reset_flush();
        test_back_to_back();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d rows left exp 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
